// File: rtl/bp_fe_btb_updater_pkg.sv
// Package for the BTB write-port updater.
// Holds the BTB geometry, the queued-update record and the PC hash.
// The hash must produce the same idx/tag that the BTB read side computes.
package bp_fe_btb_updater_pkg;

  localparam int vaddr_width_p   = 39;
  localparam int btb_idx_width_p = 6;
  localparam int btb_tag_width_p = 10;

  typedef struct packed {
    logic [btb_tag_width_p-1:0] tag;
    logic [btb_idx_width_p-1:0] idx;
  } bp_fe_btb_key_s;

  // One queued BTB write
  typedef struct packed {
    logic                       forced;
    logic                       clr;
    logic                       jmp;
    logic [btb_tag_width_p-1:0] tag;
    logic [btb_idx_width_p-1:0] idx;
    logic [vaddr_width_p-1:0]   tgt;
  } bp_fe_btb_update_s;

  // PC bit 1 folds into the index LSB only, so 2-byte-aligned branches that
  // share a word land in adjacent sets.
  function automatic bp_fe_btb_key_s bp_fe_btb_hash(input logic [vaddr_width_p-1:0] pc);
    bp_fe_btb_key_s key_s;
    key_s.idx = pc[2+:btb_idx_width_p] ^ {{(btb_idx_width_p-1){1'b0}}, pc[1]};
    key_s.tag = pc[2+btb_idx_width_p+:btb_tag_width_p];
    return key_s;
  endfunction

endpackage

// File: rtl/bp_fe_btb_updater_queue.sv
// Coalescing circular buffer of pending BTB writes.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   flush_i            drop every entry (wins over enqueue and pop)
//   enq_v_i/enq_i      new update; coalesces into a matching non-head slot
//   pop_i              retire the head entry
//   head_v_o/head_o    oldest entry and its valid
//   full_o             all slots occupied
//   hit_o              enq_i key matches a valid non-head slot
module bp_fe_btb_updater_queue
  import bp_fe_btb_updater_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic              enq_v_i,
  input  bp_fe_btb_update_s enq_i,
  input  logic              pop_i,
  output logic              head_v_o,
  output bp_fe_btb_update_s head_o,
  output logic              full_o,
  output logic              hit_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  bp_fe_btb_update_s     slot_r [els_p];
  logic [els_p-1:0]      slot_v_r;
  logic [ptr_w-1:0]      head_r, tail_r;
  logic [cnt_w-1:0]      cnt_r;
  logic [els_p-1:0]      match_s;
  logic [ptr_w-1:0]      hit_idx_s;
  logic                  do_enq_s, do_coal_s, do_pop_s;
  bp_fe_btb_update_s     merged_s;

  function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? {ptr_w{1'b0}} : p + ptr_w'(1);
  endfunction

  // Per-slot key match; the head is excluded since it may retire this cycle
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    for (int i = 0; i < els_p; i++) begin
      match_s[i] = slot_v_r[i] && (ptr_w'(i) != head_r)
                   && (slot_r[i].tag == enq_i.tag) && (slot_r[i].idx == enq_i.idx);
      hit_idx_s  = match_s[i] ? ptr_w'(i) : hit_idx_s;
    end
  end

  assign hit_o    = |match_s;
  assign full_o   = (cnt_r == cnt_w'(els_p));
  assign head_v_o = slot_v_r[head_r];
  assign head_o   = slot_r[head_r];

  // Decide the queue action and the coalesced record
  always_comb begin
    do_coal_s       = enq_v_i & hit_o;
    do_enq_s        = enq_v_i & ~hit_o & ~full_o;
    do_pop_s        = pop_i & head_v_o;
    merged_s        = enq_i;
    merged_s.forced = enq_i.forced | slot_r[hit_idx_s].forced;
  end

  // Slot storage, valid bits and pointers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) slot_r[i] <= '0;
      slot_v_r <= '0;
      head_r   <= '0;
      tail_r   <= '0;
      cnt_r    <= '0;
    end else if (flush_i) begin
      slot_v_r <= '0;
      head_r   <= '0;
      tail_r   <= '0;
      cnt_r    <= '0;
    end else begin
      if (do_coal_s) slot_r[hit_idx_s] <= merged_s;
      if (do_enq_s) begin
        slot_r[tail_r]   <= enq_i;
        slot_v_r[tail_r] <= 1'b1;
        tail_r           <= ptr_next(tail_r);
      end
      if (do_pop_s) begin
        slot_v_r[head_r] <= 1'b0;
        head_r           <= ptr_next(head_r);
      end
      cnt_r <= cnt_r + cnt_w'(do_enq_s) - cnt_w'(do_pop_s);
    end
  end

endmodule

// File: rtl/bp_fe_btb_updater.sv
// Producer side of the BTB synchronous write port.
// Hashes branch-resolution updates into idx/tag, buffers them in a coalescing
// queue and presents the head to the BTB until w_yumi_i. A head that waits
// force_after_p cycles is escalated to w_force_o so reads cannot starve it.
// Ports:
//   clk_i, reset_n_i              clock, asynchronous active-low reset
//   init_done_i                   BTB ready to accept writes
//   flush_i                       discard all queued updates
//   upd_v_i/upd_ready_and_o       update handshake; upd_pc/tgt/jmp/clr/force payload
//   w_v_o/w_force_o/w_clr_o/...   head write presented to the BTB
//   w_yumi_i                      BTB consumed the head
module bp_fe_btb_updater
  import bp_fe_btb_updater_pkg::*;
#(
  parameter int els_p         = 4,
  parameter int force_after_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       init_done_i,
  input  logic                       flush_i,
  input  logic                       upd_v_i,
  output logic                       upd_ready_and_o,
  input  logic [vaddr_width_p-1:0]   upd_pc_i,
  input  logic [vaddr_width_p-1:0]   upd_tgt_i,
  input  logic                       upd_jmp_i,
  input  logic                       upd_clr_i,
  input  logic                       upd_force_i,
  output logic                       w_v_o,
  output logic                       w_force_o,
  output logic                       w_clr_o,
  output logic                       w_jmp_o,
  output logic [btb_tag_width_p-1:0] w_tag_o,
  output logic [btb_idx_width_p-1:0] w_idx_o,
  output logic [vaddr_width_p-1:0]   w_tgt_o,
  input  logic                       w_yumi_i
);

  localparam int age_w = $clog2(force_after_p + 1);

  bp_fe_btb_key_s    key_s;
  bp_fe_btb_update_s enq_s, head_s;
  logic              head_v_s, full_s, hit_s, enq_v_s, pop_s, aged_s;
  logic [age_w-1:0]  age_r;

  // Build the queue record from the incoming update
  always_comb begin
    key_s        = bp_fe_btb_hash(upd_pc_i);
    enq_s        = '0;
    enq_s.forced = upd_force_i;
    enq_s.clr    = upd_clr_i;
    enq_s.jmp    = upd_jmp_i;
    enq_s.tag    = key_s.tag;
    enq_s.idx    = key_s.idx;
    enq_s.tgt    = upd_tgt_i;
  end

  // A full queue can still absorb an update that coalesces; no bypass on pop
  assign upd_ready_and_o = ~flush_i & (~full_s | hit_s);
  assign enq_v_s         = upd_v_i & upd_ready_and_o;
  assign w_v_o           = head_v_s & init_done_i & ~flush_i;
  assign pop_s           = w_v_o & w_yumi_i;
  assign aged_s          = (age_r == age_w'(force_after_p));
  assign w_force_o       = w_v_o & (head_s.forced | aged_s);
  assign w_clr_o         = head_s.clr;
  assign w_jmp_o         = head_s.jmp;
  assign w_tag_o         = head_s.tag;
  assign w_idx_o         = head_s.idx;
  assign w_tgt_o         = head_s.tgt;

  bp_fe_btb_updater_queue #(.els_p(els_p)) queue (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush_i),
    .enq_v_i   (enq_v_s),
    .enq_i     (enq_s),
    .pop_i     (pop_s),
    .head_v_o  (head_v_s),
    .head_o    (head_s),
    .full_o    (full_s),
    .hit_o     (hit_s)
  );

  // Head stall counter: counts refused cycles, saturates, restarts per head
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      age_r <= '0;
    end else if (flush_i || pop_s) begin
      age_r <= '0;
    end else if (w_v_o && !aged_s) begin
      age_r <= age_r + age_w'(1);
    end else begin
      age_r <= age_r;
    end
  end

endmodule

// File: tb/tb_bp_fe_btb_updater.sv
module tb_bp_fe_btb_updater;

  localparam int ELS = 4;
  localparam int FA  = 8;

  logic        clk_i = 1'b0;
  logic        reset_n_i, init_done_i, flush_i, upd_v_i;
  logic        upd_ready_and_o;
  logic [38:0] upd_pc_i, upd_tgt_i;
  logic        upd_jmp_i, upd_clr_i, upd_force_i;
  logic        w_v_o, w_force_o, w_clr_o, w_jmp_o;
  logic [9:0]  w_tag_o;
  logic [5:0]  w_idx_o;
  logic [38:0] w_tgt_o;
  logic        w_yumi_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [9:0]  tag;
    logic [38:0] tgt;
    bit          jmp, clr, frc;
  } ent_t;
  ent_t mq[$];
  int   wait_cnt = 0;

  bp_fe_btb_updater #(.els_p(ELS), .force_after_p(FA)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .init_done_i(init_done_i), .flush_i(flush_i),
    .upd_v_i(upd_v_i), .upd_ready_and_o(upd_ready_and_o), .upd_pc_i(upd_pc_i),
    .upd_tgt_i(upd_tgt_i), .upd_jmp_i(upd_jmp_i), .upd_clr_i(upd_clr_i),
    .upd_force_i(upd_force_i), .w_v_o(w_v_o), .w_force_o(w_force_o), .w_clr_o(w_clr_o),
    .w_jmp_o(w_jmp_o), .w_tag_o(w_tag_o), .w_idx_o(w_idx_o), .w_tgt_o(w_tgt_o),
    .w_yumi_i(w_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] h_idx(input logic [38:0] pc);
    return 6'(((pc >> 2) & 39'd63) ^ ((pc >> 1) & 39'd1));
  endfunction

  function automatic logic [9:0] h_tag(input logic [38:0] pc);
    return 10'((pc >> 8) & 39'd1023);
  endfunction

  // Reference model / scoreboard, evaluated mid-cycle while inputs are stable
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      mq.delete();
      wait_cnt = 0;
    end else begin
      int   hit;
      bit   exp_wv, exp_rdy;
      ent_t e;
      e.idx = h_idx(upd_pc_i);
      e.tag = h_tag(upd_pc_i);
      e.tgt = upd_tgt_i;
      e.jmp = upd_jmp_i;
      e.clr = upd_clr_i;
      e.frc = upd_force_i;
      hit = -1;
      for (int i = 1; i < mq.size(); i++)
        if (mq[i].idx == e.idx && mq[i].tag == e.tag) hit = i;
      exp_wv  = (mq.size() > 0) && init_done_i && !flush_i;
      exp_rdy = !flush_i && (mq.size() < ELS || hit >= 0);
      chk("ready", 64'(upd_ready_and_o), 64'(exp_rdy));
      chk("w_v", 64'(w_v_o), 64'(exp_wv));
      if (exp_wv) begin
        chk("w_force", 64'(w_force_o), 64'(mq[0].frc || wait_cnt >= FA));
        chk("w_idx", 64'(w_idx_o), 64'(mq[0].idx));
        chk("w_tag", 64'(w_tag_o), 64'(mq[0].tag));
        chk("w_tgt", 64'(w_tgt_o), 64'(mq[0].tgt));
        chk("w_jmp", 64'(w_jmp_o), 64'(mq[0].jmp));
        chk("w_clr", 64'(w_clr_o), 64'(mq[0].clr));
      end else begin
        chk("w_force_idle", 64'(w_force_o), 64'd0);
      end
      if (flush_i) begin
        mq.delete();
        wait_cnt = 0;
      end else begin
        if (upd_v_i && exp_rdy) begin
          if (hit >= 0) begin
            e.frc   = e.frc | mq[hit].frc;
            mq[hit] = e;
          end else begin
            mq.push_back(e);
          end
        end
        if (exp_wv && w_yumi_i) begin
          void'(mq.pop_front());
          wait_cnt = 0;
        end else if (exp_wv && wait_cnt < FA) begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [38:0] pc, input logic [38:0] tgt,
                       input bit jmp, input bit clr, input bit frc, input bit fl, input bit yw);
    @(posedge clk_i);
    #1;
    upd_v_i = v; upd_pc_i = pc; upd_tgt_i = tgt;
    upd_jmp_i = jmp; upd_clr_i = clr; upd_force_i = frc; flush_i = fl;
    #1;
    w_yumi_i = yw & w_v_o;
  endtask

  task automatic idle(input int n, input bit yw);
    for (int i = 0; i < n; i++) drive(1'b0, 39'd0, 39'd0, 1'b0, 1'b0, 1'b0, 1'b0, yw);
  endtask

  function automatic logic [38:0] rand_pc();
    return 39'(($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2) | ($urandom_range(0, 1) << 1));
  endfunction

  initial begin
    reset_n_i = 1'b0; init_done_i = 1'b0; flush_i = 1'b0; upd_v_i = 1'b0;
    upd_pc_i = '0; upd_tgt_i = '0; upd_jmp_i = 1'b0; upd_clr_i = 1'b0;
    upd_force_i = 1'b0; w_yumi_i = 1'b0;
    #3;
    chk("rst_w_v", 64'(w_v_o), 64'd0);
    chk("rst_w_force", 64'(w_force_o), 64'd0);
    chk("rst_w_data", 64'({w_tag_o, w_idx_o, w_tgt_o, w_jmp_o, w_clr_o}), 64'd0);
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    #1 chk("rst_ready", 64'(upd_ready_and_o), 64'd1);
    init_done_i = 1'b1;

    // Basic hash and one-cycle latency
    drive(1'b1, 39'h1000, 39'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("first_w_v", 64'(w_v_o), 64'd1);
    chk("first_idx", 64'(w_idx_o), 64'h00);
    chk("first_tag", 64'(w_tag_o), 64'h010);
    chk("first_tgt", 64'(w_tgt_o), 64'h2000);
    idle(1, 1'b1);
    drive(1'b1, 39'h1002, 39'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("pc1_idx", 64'(w_idx_o), 64'h01);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("after_yumi_w_v", 64'(w_v_o), 64'd0);

    // Aging: force must appear after FA stalled cycles
    drive(1'b1, 39'h4000, 39'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(FA, 1'b0);
    chk("force_early", 64'(w_force_o), 64'd0);
    idle(1, 1'b0);
    chk("force_on_time", 64'(w_force_o), 64'd1);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // Queue fills while BTB is still initialising, then drains in order
    init_done_i = 1'b0;
    drive(1'b1, 39'h5000, 39'h51, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 39'h6000, 39'h61, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    init_done_i = 1'b1;
    idle(4, 1'b1);

    // Full queue accepts only a coalescing update
    drive(1'b1, 39'h0100, 39'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 39'h0200, 39'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 39'h0300, 39'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 39'h0400, 39'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("full_not_ready", 64'(upd_ready_and_o), 64'd0);
    drive(1'b1, 39'h0300, 39'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Flush with entries queued
    drive(1'b1, 39'h0500, 39'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 39'h0600, 39'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 39'h0700, 39'hC2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 39'd0, 39'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 4) init_done_i = ~init_done_i;
      drive($urandom_range(0, 99) < 70, rand_pc(), 39'({$urandom(), $urandom()}),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 55);
    end
    init_done_i = 1'b1;

    // Asynchronous reset in the middle of a drain
    drive(1'b1, 39'h0800, 39'hD0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 39'h0900, 39'hD1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 39'h0A00, 39'hD2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    #1;
    upd_v_i = 1'b0; w_yumi_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_w_v", 64'(w_v_o), 64'd0);
    chk("mid_rst_force", 64'(w_force_o), 64'd0);
    chk("mid_rst_data", 64'({w_tag_o, w_idx_o, w_tgt_o, w_jmp_o, w_clr_o}), 64'd0);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    idle(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
